// File: rtl/smiley_hit_ctrl_if.sv
// Signal bundle between the drawing-request mux, the hit controller and the smiley mover.
// The master drives scan position and drawing requests; the slave returns movement commands.
interface smiley_hit_ctrl_if;
    logic        startOfFrame;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic        smileyDR;
    logic        obstacleDR;
    logic        borderDR;
    logic        collision;
    logic        X_direction;
    logic        toggleY;
    logic [7:0]  hitCount;

    modport master (
        output startOfFrame, pixelX, pixelY, smileyDR, obstacleDR, borderDR,
        input  collision, X_direction, toggleY, hitCount
    );

    modport slave (
        input  startOfFrame, pixelX, pixelY, smileyDR, obstacleDR, borderDR,
        output collision, X_direction, toggleY, hitCount
    );
endinterface

// File: rtl/smiley_hit_ctrl.sv
// Frame-based hit controller: collects smiley/obstacle/border overlaps during a frame and
// turns them into collision, X_direction and toggleY commands at the next startOfFrame.
module smiley_hit_ctrl #(
    parameter int SCREEN_W       = 640,
    parameter int SCREEN_H       = 480,
    parameter int EDGE           = 8,
    parameter int LOCKOUT_FRAMES = 4,
    parameter int TOGGLE_HOLD    = 2
) (
    input logic          clk,
    input logic          resetN,
    smiley_hit_ctrl_if.slave bus
);

    localparam int LW = (LOCKOUT_FRAMES > 0) ? $clog2(LOCKOUT_FRAMES + 1) : 1;
    localparam int HW = (TOGGLE_HOLD > 1) ? $clog2(TOGGLE_HOLD + 1) : 1;

    localparam logic [10:0] LEFT_LIM   = 11'(EDGE);
    localparam logic [10:0] RIGHT_LIM  = 11'(SCREEN_W - EDGE);
    localparam logic [10:0] TOP_LIM    = 11'(EDGE);
    localparam logic [10:0] BOTTOM_LIM = 11'(SCREEN_H - EDGE);

    typedef enum logic {ARMED, LOCKOUT} state_t;

    state_t          state, state_n;
    logic            obs_flag, obs_flag_n;
    logic            brd_flag, brd_flag_n;
    logic [10:0]     hit_x, hit_x_n;
    logic [10:0]     hit_y, hit_y_n;
    logic [LW-1:0]   lock_cnt, lock_cnt_n;
    logic [HW-1:0]   hold_cnt, hold_cnt_n;
    logic            collision_r, collision_n;
    logic            x_dir, x_dir_n;
    logic            toggle_r, toggle_n;
    logic [7:0]      hit_count, hit_count_n;

    logic obs_hit;
    logic brd_hit;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign obs_hit = bus.smileyDR && bus.obstacleDR;
    assign brd_hit = bus.smileyDR && bus.borderDR;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state       <= ARMED;
            obs_flag    <= 1'b0;
            brd_flag    <= 1'b0;
            hit_x       <= '0;
            hit_y       <= '0;
            lock_cnt    <= '0;
            hold_cnt    <= '0;
            collision_r <= 1'b0;
            x_dir       <= 1'b1;
            toggle_r    <= 1'b0;
            hit_count   <= '0;
        end else begin
            state       <= state_n;
            obs_flag    <= obs_flag_n;
            brd_flag    <= brd_flag_n;
            hit_x       <= hit_x_n;
            hit_y       <= hit_y_n;
            lock_cnt    <= lock_cnt_n;
            hold_cnt    <= hold_cnt_n;
            collision_r <= collision_n;
            x_dir       <= x_dir_n;
            toggle_r    <= toggle_n;
            hit_count   <= hit_count_n;
        end
    end

    always_comb begin
        state_n     = state;
        obs_flag_n  = obs_flag;
        brd_flag_n  = brd_flag;
        hit_x_n     = hit_x;
        hit_y_n     = hit_y;
        lock_cnt_n  = lock_cnt;
        hold_cnt_n  = (hold_cnt != '0) ? hold_cnt - HW'(1) : '0;
        collision_n = 1'b0;
        x_dir_n     = x_dir;
        hit_count_n = hit_count;

        case (state)
            ARMED: begin
                if (bus.startOfFrame) begin
                    obs_flag_n = 1'b0;
                    brd_flag_n = 1'b0;
                    hit_x_n    = '0;
                    hit_y_n    = '0;
                    if (obs_flag) begin
                        collision_n = 1'b1;
                        hit_count_n = sat_inc8(hit_count);
                        if (LOCKOUT_FRAMES > 0) begin
                            state_n    = LOCKOUT;
                            lock_cnt_n = LW'(LOCKOUT_FRAMES);
                        end
                    end else if (brd_flag) begin
                        if (hit_x < LEFT_LIM) begin
                            x_dir_n = 1'b1;
                        end else if (hit_x >= RIGHT_LIM) begin
                            x_dir_n = 1'b0;
                        end
                        if ((hit_y < TOP_LIM) || (hit_y >= BOTTOM_LIM)) begin
                            hold_cnt_n = HW'(TOGGLE_HOLD);
                        end
                    end
                    // An overlap on the SOF cycle belongs to the frame that starts here.
                    if (state_n == ARMED) begin
                        if (obs_hit) begin
                            obs_flag_n = 1'b1;
                        end
                        if (brd_hit) begin
                            brd_flag_n = 1'b1;
                            hit_x_n    = bus.pixelX;
                            hit_y_n    = bus.pixelY;
                        end
                    end
                end else begin
                    if (obs_hit) begin
                        obs_flag_n = 1'b1;
                    end
                    if (brd_hit && !brd_flag) begin
                        brd_flag_n = 1'b1;
                        hit_x_n    = bus.pixelX;
                        hit_y_n    = bus.pixelY;
                    end
                end
            end
            LOCKOUT: begin
                obs_flag_n = 1'b0;
                brd_flag_n = 1'b0;
                hit_x_n    = '0;
                hit_y_n    = '0;
                if (bus.startOfFrame) begin
                    lock_cnt_n = lock_cnt - LW'(1);
                    if (lock_cnt == LW'(1)) begin
                        state_n = ARMED;
                    end
                end
            end
            default: state_n = ARMED;
        endcase

        toggle_n = (hold_cnt_n != '0);
    end

    assign bus.collision   = collision_r;
    assign bus.X_direction = x_dir;
    assign bus.toggleY     = toggle_r;
    assign bus.hitCount    = hit_count;

endmodule

// File: tb/tb_smiley_hit_ctrl.sv
// Directed bench for smiley_hit_ctrl: a default instance (lockout 4, hold 2) and a
// no-lockout instance sharing the same stimulus, used for hitCount saturation.
module tb_smiley_hit_ctrl;

    logic clk;
    logic resetN;
    int   n_checks;
    int   n_errors;
    int   pulses;

    smiley_hit_ctrl_if bus0();
    smiley_hit_ctrl_if bus1();

    assign bus1.startOfFrame = bus0.startOfFrame;
    assign bus1.pixelX       = bus0.pixelX;
    assign bus1.pixelY       = bus0.pixelY;
    assign bus1.smileyDR     = bus0.smileyDR;
    assign bus1.obstacleDR   = bus0.obstacleDR;
    assign bus1.borderDR     = bus0.borderDR;

    smiley_hit_ctrl dut0 (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus0.slave)
    );

    smiley_hit_ctrl #(.LOCKOUT_FRAMES(0)) dut1 (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic overlap(input int x, input int y, input logic obs, input logic brd);
        bus0.pixelX     = 11'(x);
        bus0.pixelY     = 11'(y);
        bus0.smileyDR   = 1'b1;
        bus0.obstacleDR = obs;
        bus0.borderDR   = brd;
        step();
        bus0.smileyDR   = 1'b0;
        bus0.obstacleDR = 1'b0;
        bus0.borderDR   = 1'b0;
    endtask

    // Returns in the SOF+1 cycle, where the decision is visible.
    task automatic do_sof();
        bus0.startOfFrame = 1'b1;
        step();
        bus0.startOfFrame = 1'b0;
    endtask

    task automatic quiet_frames(input int n);
        for (int i = 0; i < n; i++) begin
            idle(3);
            do_sof();
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        pulses   = 0;
        resetN   = 1'b0;
        bus0.startOfFrame = 1'b0;
        bus0.pixelX       = '0;
        bus0.pixelY       = '0;
        bus0.smileyDR     = 1'b0;
        bus0.obstacleDR   = 1'b0;
        bus0.borderDR     = 1'b0;
        idle(3);
        check("rst_collision", bus0.collision, 0);
        check("rst_xdir", bus0.X_direction, 1);
        check("rst_toggle", bus0.toggleY, 0);
        check("rst_hits", bus0.hitCount, 0);
        resetN = 1'b1;
        idle(2);
        do_sof();
        check("rst_no_pulse", bus0.collision, 0);

        // Obstacle collision, then four locked-out frames
        idle(3);
        overlap(100, 100, 1'b1, 1'b0);
        idle(2);
        do_sof();
        check("obs_pulse", bus0.collision, 1);
        check("obs_count1", bus0.hitCount, 1);
        step();
        check("obs_pulse_end", bus0.collision, 0);
        for (int f = 0; f < 4; f++) begin
            idle(2);
            overlap(100, 100, 1'b1, 1'b0);
            do_sof();
            check("lockout_no_pulse", bus0.collision, 0);
        end
        check("lockout_count", bus0.hitCount, 1);
        idle(2);
        overlap(100, 100, 1'b1, 1'b0);
        do_sof();
        check("post_lock_pulse", bus0.collision, 1);
        check("post_lock_count", bus0.hitCount, 2);
        quiet_frames(4);

        // Side hits
        idle(2);
        overlap(636, 200, 1'b0, 1'b1);
        do_sof();
        check("right_xdir", bus0.X_direction, 0);
        check("right_no_toggle", bus0.toggleY, 0);
        idle(2);
        overlap(3, 200, 1'b0, 1'b1);
        do_sof();
        check("left_xdir", bus0.X_direction, 1);
        check("left_no_toggle", bus0.toggleY, 0);
        idle(2);
        overlap(636, 200, 1'b0, 1'b1);
        idle(1);
        overlap(3, 300, 1'b0, 1'b1);
        do_sof();
        check("first_capture", bus0.X_direction, 0);

        // Top and corner hits
        idle(3);
        overlap(300, 2, 1'b0, 1'b1);
        do_sof();
        check("top_toggle1", bus0.toggleY, 1);
        check("top_xdir", bus0.X_direction, 0);
        step();
        check("top_toggle2", bus0.toggleY, 1);
        step();
        check("top_toggle_end", bus0.toggleY, 0);
        idle(2);
        overlap(2, 477, 1'b0, 1'b1);
        do_sof();
        check("corner_xdir", bus0.X_direction, 1);
        check("corner_toggle1", bus0.toggleY, 1);
        step();
        check("corner_toggle2", bus0.toggleY, 1);
        step();
        check("corner_toggle_end", bus0.toggleY, 0);
        idle(2);
        overlap(300, 200, 1'b0, 1'b1);
        do_sof();
        check("mid_xdir", bus0.X_direction, 1);
        check("mid_toggle", bus0.toggleY, 0);

        // Obstacle beats border in the same frame
        idle(2);
        overlap(636, 200, 1'b0, 1'b1);
        do_sof();
        check("pre_prio_xdir", bus0.X_direction, 0);
        idle(2);
        overlap(5, 200, 1'b1, 1'b1);
        do_sof();
        check("prio_pulse", bus0.collision, 1);
        check("prio_xdir", bus0.X_direction, 0);
        check("prio_toggle", bus0.toggleY, 0);
        check("prio_count", bus0.hitCount, 3);
        quiet_frames(4);

        // Overlap only on the SOF cycle lands in the following frame
        idle(3);
        bus0.pixelX       = 11'd3;
        bus0.pixelY       = 11'd200;
        bus0.smileyDR     = 1'b1;
        bus0.borderDR     = 1'b1;
        bus0.startOfFrame = 1'b1;
        step();
        bus0.startOfFrame = 1'b0;
        bus0.smileyDR     = 1'b0;
        bus0.borderDR     = 1'b0;
        check("sof_ovl_not_now", bus0.X_direction, 0);
        idle(3);
        do_sof();
        check("sof_ovl_next", bus0.X_direction, 1);

        // Asynchronous reset truncates a pending toggle and drops a pending obstacle
        idle(2);
        overlap(636, 2, 1'b0, 1'b1);
        do_sof();
        check("pre_rst_xdir", bus0.X_direction, 0);
        check("pre_rst_toggle", bus0.toggleY, 1);
        overlap(100, 100, 1'b1, 1'b0);
        resetN = 1'b0;
        #1;
        check("mid_rst_toggle", bus0.toggleY, 0);
        check("mid_rst_xdir", bus0.X_direction, 1);
        check("mid_rst_hits", bus0.hitCount, 0);
        check("mid_rst_collision", bus0.collision, 0);
        step();
        resetN = 1'b1;
        idle(2);
        do_sof();
        check("post_rst_no_pulse", bus0.collision, 0);
        check("post_rst_hits", bus0.hitCount, 0);

        // Saturation on the no-lockout instance
        for (int f = 1; f <= 260; f++) begin
            overlap(100, 100, 1'b1, 1'b0);
            do_sof();
            if (bus1.collision) pulses++;
            if (f == 1) check("sat_count1", bus1.hitCount, 1);
            if (f == 255) check("sat_count255", bus1.hitCount, 255);
        end
        check("sat_pulses", 32'(pulses), 260);
        check("sat_count_hold", bus1.hitCount, 255);
        step();
        check("sat_pulse_end", bus1.collision, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
